pe_carry_normalizer: RTL and testbench

- Downstream consumer of the PE arithmetic unit's 48-bit P output.
- Takes a frame of unsigned column sums (one per coefficient position, LSB column first) and propagates carries across them.
- Emits normalised LIMB_W-bit limbs on a valid/ready stream, followed by FLUSH_LIMBS carry limbs, so the AMNS result returns in the limb radix the PE operand ports expect.

---
 rtl/pe_carry_normalizer_if.sv | 25 ++
 rtl/pe_carry_normalizer.sv | 144 ++++++++++++++
 tb/tb_pe_carry_normalizer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pe_carry_normalizer_if.sv
// Stream bundle for the carry normaliser: 48-bit column sums in, LIMB_W-bit
// normalised limbs out, plus the frame-busy indication.
interface pe_carry_normalizer_if #(
    parameter int LIMB_W = 17
);
    logic              p_valid_i;
    logic              p_ready_o;
    logic [47:0]       p_i;
    logic              p_last_i;
    logic              limb_valid_o;
    logic              limb_ready_i;
    logic [LIMB_W-1:0] limb_o;
    logic              limb_last_o;
    logic              busy_o;

    modport master (
        output p_valid_i, p_i, p_last_i, limb_ready_i,
        input  p_ready_o, limb_valid_o, limb_o, limb_last_o, busy_o
    );

    modport slave (
        input  p_valid_i, p_i, p_last_i, limb_ready_i,
        output p_ready_o, limb_valid_o, limb_o, limb_last_o, busy_o
    );
endinterface

// File: rtl/pe_carry_normalizer.sv
// Propagates carries across a frame of 48-bit column sums and emits LIMB_W-bit
// limbs, followed by FLUSH_LIMBS limbs that drain the remaining carry.
module pe_carry_normalizer #(
    parameter int LIMB_W      = 17,
    parameter int FLUSH_LIMBS = 2
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    pe_carry_normalizer_if.slave    bus
);
    localparam int SUM_W   = 49;
    localparam int CARRY_W = SUM_W - LIMB_W;
    localparam int CNT_W   = (FLUSH_LIMBS > 1) ? $clog2(FLUSH_LIMBS) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [CARRY_W-1:0]   carry_q, carry_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LIMB_W-1:0]    limb_q, limb_d;
    logic                 limb_valid_q, limb_valid_d;
    logic                 limb_last_q, limb_last_d;
    logic                 busy_q, busy_d;

    logic                 out_free;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 flush_last;
    logic                 p_ready;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     carry_ext;

    function automatic logic [LIMB_W-1:0] low_limb(input logic [SUM_W-1:0] v);
        return LIMB_W'(v);
    endfunction

    function automatic logic [CARRY_W-1:0] carry_out(input logic [SUM_W-1:0] v);
        return CARRY_W'(v >> LIMB_W);
    endfunction

    assign out_free   = !limb_valid_q || bus.limb_ready_i;
    assign in_xfer    = bus.p_valid_i && p_ready;
    assign out_xfer   = limb_valid_q && bus.limb_ready_i;
    assign flush_last = (cnt_q == CNT_W'(FLUSH_LIMBS - 1));

    // Carry is narrower than a limb's headroom, so the 49-bit sum cannot overflow.
    assign carry_ext  = {{LIMB_W{1'b0}}, carry_q};
    assign sum        = {1'b0, bus.p_i} + carry_ext;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (in_xfer && bus.p_last_i) state_d = FLUSH;
            FLUSH:   if (out_free && flush_last)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        p_ready = 1'b0;
        if (state_q == RUN) begin
            p_ready = out_free;
        end
    end

    always_comb begin
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        limb_d       = limb_q;
        limb_valid_d = limb_valid_q;
        limb_last_d  = limb_last_q;
        case (state_q)
            RUN: begin
                if (in_xfer) begin
                    limb_d       = low_limb(sum);
                    limb_valid_d = 1'b1;
                    limb_last_d  = 1'b0;
                    carry_d      = carry_out(sum);
                    cnt_d        = '0;
                end else if (out_free) begin
                    limb_valid_d = 1'b0;
                    limb_last_d  = 1'b0;
                end
            end
            FLUSH: begin
                // Flush limbs are issued even for a zero carry to keep frame length fixed.
                if (out_free) begin
                    limb_d       = low_limb(carry_ext);
                    limb_valid_d = 1'b1;
                    limb_last_d  = flush_last;
                    if (flush_last) begin
                        carry_d = '0;
                        cnt_d   = '0;
                    end else begin
                        carry_d = carry_out(carry_ext);
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (in_xfer) begin
            busy_d = 1'b1;
        end else if (out_xfer && limb_last_q) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            carry_q      <= '0;
            cnt_q        <= '0;
            limb_q       <= '0;
            limb_valid_q <= 1'b0;
            limb_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            limb_q       <= limb_d;
            limb_valid_q <= limb_valid_d;
            limb_last_q  <= limb_last_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.p_ready_o    = p_ready;
    assign bus.limb_valid_o = limb_valid_q;
    assign bus.limb_o       = limb_q;
    assign bus.limb_last_o  = limb_last_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_pe_carry_normalizer.sv
// Directed and randomised bench for pe_carry_normalizer with LIMB_W=17,
// FLUSH_LIMBS=2.
module tb_pe_carry_normalizer;
    localparam int LW = 17;
    localparam int FL = 2;
    localparam logic [48:0] L49 = 49'h1_0000_0000_0000;
    localparam logic [17:0] L18 = 18'h20000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_carry_normalizer_if #(.LIMB_W(LW)) bus ();

    pe_carry_normalizer #(.LIMB_W(LW), .FLUSH_LIMBS(FL)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int          rmode;
        int          vmode;
        int          ncol;
        logic [48:0] col[4];
        int          nl;
        logic [17:0] e[6];
    } vec_t;

    vec_t        tbl[6];
    logic [48:0] col_q[$];
    logic [17:0] got_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // rmode: 0 ready high, 1 ready toggles 1010.., 2 random. vmode: 0 valid high, 1 random.
    task automatic run_frames(input int rmode, input int vmode, input int exp_limbs);
        int          sent     = 0;
        int          cyc      = 0;
        int          first_in = -1;
        bit          hold     = 1'b0;
        bit          stall    = 1'b0;
        logic [17:0] stall_v  = '0;
        got_q.delete();
        while ((sent < col_q.size() || got_q.size() < exp_limbs) && cyc < 4000) begin
            @(negedge clk);
            case (rmode)
                0:       bus.limb_ready_i = 1'b1;
                1:       bus.limb_ready_i = (cyc % 2 == 0);
                default: bus.limb_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (sent < col_q.size()) begin
                if (!hold) bus.p_valid_i = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                {bus.p_last_i, bus.p_i} = col_q[sent];
            end else begin
                bus.p_valid_i = 1'b0;
                bus.p_last_i  = 1'b0;
                bus.p_i       = '0;
            end
            #1;
            if (stall)
                check("stall_hold", {bus.limb_valid_o, bus.limb_last_o, bus.limb_o}, {1'b1, stall_v});
            if (first_in >= 0 && cyc == first_in + 1)
                check("first_latency", bus.limb_valid_o, 1);
            stall   = bus.limb_valid_o && !bus.limb_ready_i;
            stall_v = {bus.limb_last_o, bus.limb_o};
            hold    = bus.p_valid_i && !bus.p_ready_o;
            if (bus.p_valid_i && bus.p_ready_o) begin
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            if (bus.limb_valid_o && bus.limb_ready_i)
                got_q.push_back({bus.limb_last_o, bus.limb_o});
            cyc++;
        end
        if (cyc >= 4000) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d limbs required %0d", got_q.size(), exp_limbs);
        end
        @(negedge clk);
        bus.p_valid_i    = 1'b0;
        bus.limb_ready_i = 1'b0;
        #1;
        check("busy_after_frame", bus.busy_o, 0);
    endtask

    initial begin
        logic [63:0]  r64;
        logic [511:0] ref_v;
        logic [511:0] reasm;
        int           n;
        int           bad_last;

        tbl[0].rmode = 0; tbl[0].vmode = 0; tbl[0].ncol = 2; tbl[0].nl = 4;
        tbl[0].col = '{49'h30005, L49 | 49'h1FFFF, 49'h0, 49'h0};
        tbl[0].e   = '{18'h10005, 18'h0, 18'h1, L18, 18'h0, 18'h0};
        tbl[1].rmode = 0; tbl[1].vmode = 0; tbl[1].ncol = 1; tbl[1].nl = 3;
        tbl[1].col = '{L49 | 49'hFFFF_FFFF_FFFF, 49'h0, 49'h0, 49'h0};
        tbl[1].e   = '{18'h1FFFF, 18'h1FFFF, L18 | 18'h3FFF, 18'h0, 18'h0, 18'h0};
        for (int i = 2; i < 5; i++) begin
            tbl[i].rmode = i - 2; tbl[i].vmode = (i == 4) ? 1 : 0; tbl[i].ncol = 4; tbl[i].nl = 6;
            tbl[i].col = '{49'h2_0000_0001, 49'h2_0000_0001, 49'h2_0000_0001, L49 | 49'h2_0000_0001};
            tbl[i].e   = '{18'h1, 18'h10001, 18'h10001, 18'h10001, 18'h10000, L18};
        end
        tbl[5].rmode = 0; tbl[5].vmode = 0; tbl[5].ncol = 2; tbl[5].nl = 6;
        tbl[5].col = '{L49 | 49'h40000, L49 | 49'h5, 49'h0, 49'h0};
        tbl[5].e   = '{18'h0, 18'h2, L18, 18'h5, 18'h0, L18};

        bus.p_valid_i    = 1'b0;
        bus.p_i          = '0;
        bus.p_last_i     = 1'b0;
        bus.limb_ready_i = 1'b0;
        rst_n            = 1'b0;
        #12;
        check("reset_outputs", {bus.limb_valid_o, bus.limb_last_o, bus.busy_o, bus.limb_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("ready_after_reset", bus.p_ready_o, 1);

        for (int i = 0; i < 6; i++) begin
            col_q.delete();
            for (int j = 0; j < tbl[i].ncol; j++) col_q.push_back(tbl[i].col[j]);
            run_frames(tbl[i].rmode, tbl[i].vmode, tbl[i].nl);
            check($sformatf("vec%0d_count", i), got_q.size(), tbl[i].nl);
            for (int k = 0; k < tbl[i].nl && k < got_q.size(); k++)
                check($sformatf("vec%0d_limb%0d", i, k), got_q[k], tbl[i].e[k]);
        end

        // Abort a frame after two of its columns have been accepted.
        @(negedge clk);
        bus.limb_ready_i = 1'b1;
        bus.p_valid_i    = 1'b1;
        bus.p_last_i     = 1'b0;
        bus.p_i          = 48'h30005;
        @(negedge clk);
        @(negedge clk);
        bus.p_valid_i = 1'b0;
        bus.limb_ready_i = 1'b0;
        #1;
        check("busy_mid_frame", {bus.busy_o, bus.limb_valid_o}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_frame", {bus.limb_valid_o, bus.limb_last_o, bus.busy_o, bus.limb_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        col_q.delete();
        col_q.push_back(L49 | 49'h7);
        run_frames(0, 0, 3);
        check("post_reset_count", got_q.size(), 3);
        for (int k = 0; k < 3 && k < got_q.size(); k++)
            check($sformatf("post_reset_limb%0d", k), got_q[k], (k == 0) ? 18'h7 : (k == 2) ? L18 : 18'h0);

        for (int f = 0; f < 150; f++) begin
            n = $urandom_range(1, 16);
            ref_v = '0;
            col_q.delete();
            for (int j = 0; j < n; j++) begin
                r64 = {$urandom, $urandom};
                ref_v = ref_v + (512'(r64[47:0]) << (17 * j));
                col_q.push_back({(j == n - 1) ? 1'b1 : 1'b0, r64[47:0]});
            end
            run_frames(2, 1, n + FL);
            reasm    = '0;
            bad_last = 0;
            for (int k = 0; k < got_q.size(); k++) begin
                reasm = reasm + (512'(got_q[k][16:0]) << (17 * k));
                if (got_q[k][17] != (k == n + FL - 1)) bad_last++;
            end
            check($sformatf("sweep%0d_count", f), got_q.size(), n + FL);
            check($sformatf("sweep%0d_value", f), reasm, ref_v);
            check($sformatf("sweep%0d_last", f), bad_last, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
